dispatch_issue_queue: RTL and testbench
=======================================

# dispatch_issue_queue

Dual-issue instruction buffer and issue scheduler between the decoder and the dispatch/regfile-read stage. Accepts up to two decoded instructions per cycle into an in-order circular queue. Each cycle it selects 0, 1 or 2 head entries for issue under pairing and load-use rules, and registers them as the per-slot issue outputs. It produces the dispatch stall toward ctrl and obeys ctrl flush/stall.

## Interface
Parameters:
- DEPTH, 8, queue entries; power of two, ≥4
- DECODER_WIDTH, 2, enqueue lanes (fixed 2)
- ISSUE_WIDTH, 2, issue slots (fixed 2)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  ctrl flush; drops queue and issue registers
- stall  in  1  ctrl pause of dispatch stage; freezes dequeue and issue registers
- in_valid  in  [DECODER_WIDTH-1:0]  per-lane enqueue request
- in_inst  in  id_dispatch_t [DECODER_WIDTH]  decoded instructions
- in_ready  out  1  queue can accept two entries this cycle
- pause_dispatch  out  1  equals ~in_ready; to ctrl
- issue_en  out  [ISSUE_WIDTH-1:0]  registered per-slot valid
- issue_inst  out  id_dispatch_t [ISSUE_WIDTH]  registered per-slot instruction

## Operation
- Consumed id_dispatch_t fields: reg_read_en[1:0], reg_read_addr[1:0], reg_write_en, reg_write_addr, is_load, is_mem, is_branch, is_serial.
- State: entry array, head and tail pointers of log2(DEPTH)+1 bits (MSB wraps), count 0..DEPTH.
- Enqueue:
  - Happens when in_ready && !flush.
  - Lanes are compacted. A lone valid lane 1 is written at tail. Two valid lanes are written lane 0 at tail, lane 1 at tail+1.
  - tail advances by popcount(in_valid).
  - in_valid with in_ready=0 is ignored; the decoder must hold.
- in_ready = (DEPTH − count) ≥ 2. The check uses current count only, with no credit for same-cycle dequeue.
- Slot 0 candidate is the head, if count ≥ 1. It issues unless there is a load-use hazard:
  - some slot of the current issue register holds is_load && reg_write_en && reg_write_addr≠0, and
  - a candidate read (reg_read_en[k]) matches that address.
- Slot 1 candidate is head+1, if count ≥ 2. It issues only if all of the following hold:
  - slot 0 issues;
  - it has no load-use hazard;
  - neither of its enabled reads matches slot 0 reg_write_addr (when slot 0 writes a nonzero register);
  - it is not is_mem while slot 0 is is_mem;
  - slot 0 is not is_branch;
  - neither slot is is_serial.
- Issue is in order; slot 1 never issues without slot 0.
- Dequeue: head advances by the issue count when !stall && !flush. count updates by +enq −deq in the same edge.
- Issue registers:
  - on flush, cleared;
  - else on stall, held;
  - else loaded with the selected candidates; non-issued slots get issue_en=0 and issue_inst=0.
- Priority: reset > flush > stall > normal.

## Timing
- Reset values: head=tail=count=0, issue_en=0, issue_inst=all-zero, in_ready=1, pause_dispatch=0.
- Latency: an instruction enqueued at edge E is a candidate in the cycle after E. It appears on issue_en/issue_inst after edge E+1 at the earliest. There is no bypass from in_inst.
- Load-use costs exactly one bubble cycle, which is slot 0 with issue_en=0.
- Flush takes effect at the edge it is sampled. Same-cycle inputs are discarded, and the queue is empty the following cycle with in_ready=1.
- During stall, enqueue continues while in_ready=1, so count may reach DEPTH−1 or DEPTH. With count = DEPTH−1, in_ready=0.
- Pointer wrap: the MSB toggles on wrap; full/empty are derived from count, never from pointer comparison alone.
- Asynchronous reset mid-operation clears all state immediately; no entry survives.

## Structure
- pipeline_types holds:
  - ISSUE_QUEUE_DEPTH (default for DEPTH);
  - the id_dispatch_t fields is_load, is_mem, is_branch, is_serial, added if absent;
  - the issue-count type logic[1:0].
- One combinational sub-module, issue_pair_check: takes the two candidates plus the current issue registers and returns issue_en_next[1:0]. This keeps the pairing rules unit-testable.

## Test plan
- Reset, then enqueue add r1 and add r2 with independent registers, no stall → issue_en=2'b11 one cycle later, issue_inst order preserved.
- Enqueue add r3←r1,r2 then sub r4←r3,r5 → cycle N issue_en=2'b01 (add), cycle N+1 issue_en=2'b01 (sub).
- Enqueue ld.w r6 then add r7←r6,r0 → ld issues alone, then one bubble with issue_en=2'b00, then add issues.
- stall held 6 cycles while enqueuing 2 per cycle with DEPTH=8 → in_ready falls when count=7, pause_dispatch=1, issue registers unchanged. Release → drains 2 per cycle in order.
- Fill to count=5, head near index 7 (wrap), assert flush together with in_valid=2'b11 → next cycle count=0, issue_en=0, in_ready=1, flushed inputs never issued.
- Assert rst low asynchronously mid-drain → issue_en=0 before the next clk edge, queue empty after release.

Source files
------------

// File: rtl/dispatch_issue_queue_pkg.sv
// Shared pipeline types for the decode -> dispatch boundary: the decoded
// instruction record, the issue-count type and the default queue depth.
package pipeline_types;

    localparam int ISSUE_QUEUE_DEPTH = 8;
    localparam int REG_ADDR_W        = 5;

    typedef logic [1:0] issue_cnt_t;

    typedef struct packed {
        logic [15:0]                 payload;  // opcode/immediate carried through untouched
        logic [1:0]                  reg_read_en;
        logic [1:0][REG_ADDR_W-1:0]  reg_read_addr;
        logic                        reg_write_en;
        logic [REG_ADDR_W-1:0]       reg_write_addr;
        logic                        is_load;
        logic                        is_mem;
        logic                        is_branch;
        logic                        is_serial;
    } id_dispatch_t;

    function automatic issue_cnt_t lane_count(input logic [1:0] v);
        return issue_cnt_t'({1'b0, v[0]} + {1'b0, v[1]});
    endfunction

endpackage

// File: rtl/dispatch_issue_queue_issue_pair_check.sv
// Pairing and load-use rules for the two head candidates of the issue queue.
// Purely combinational so the rules can be exercised in isolation.
module issue_pair_check
    import pipeline_types::*;
(
    input  logic [1:0]   cand_valid,
    input  id_dispatch_t cand [2],
    input  logic [1:0]   cur_issue_en,
    input  id_dispatch_t cur_issue_inst [2],
    output logic [1:0]   issue_en_next
);

    function automatic logic reads_reg(input id_dispatch_t inst, input logic [REG_ADDR_W-1:0] addr);
        return (inst.reg_read_en[0] && (inst.reg_read_addr[0] == addr)) ||
               (inst.reg_read_en[1] && (inst.reg_read_addr[1] == addr));
    endfunction

    function automatic logic writes_nonzero(input id_dispatch_t inst);
        return inst.reg_write_en && (inst.reg_write_addr != '0);
    endfunction

    logic [1:0] load_use;
    logic       raw_pair;
    logic       pair_ok;

    // A load sitting in the issue register has no result yet: its consumers wait one cycle.
    always_comb begin
        load_use = '0;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                if (cur_issue_en[s] && cur_issue_inst[s].is_load && writes_nonzero(cur_issue_inst[s]) &&
                    reads_reg(cand[c], cur_issue_inst[s].reg_write_addr)) begin
                    load_use[c] = 1'b1;
                end
            end
        end
    end

    assign raw_pair = writes_nonzero(cand[0]) && reads_reg(cand[1], cand[0].reg_write_addr);

    assign pair_ok = !load_use[1] && !raw_pair &&
                     !(cand[0].is_mem && cand[1].is_mem) &&
                     !cand[0].is_branch &&
                     !cand[0].is_serial && !cand[1].is_serial;

    assign issue_en_next[0] = cand_valid[0] && !load_use[0];
    assign issue_en_next[1] = issue_en_next[0] && cand_valid[1] && pair_ok;

endmodule

// File: rtl/dispatch_issue_queue.sv
// Dual-issue in-order instruction queue between decode and dispatch: accepts up to
// two instructions per cycle and registers 0..2 head entries per cycle for issue.
module dispatch_issue_queue
    import pipeline_types::*;
#(
    parameter int DEPTH         = ISSUE_QUEUE_DEPTH,
    parameter int DECODER_WIDTH = 2,
    parameter int ISSUE_WIDTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     stall,
    input  logic [DECODER_WIDTH-1:0] in_valid,
    input  id_dispatch_t             in_inst [DECODER_WIDTH],
    output logic                     in_ready,
    output logic                     pause_dispatch,
    output logic [ISSUE_WIDTH-1:0]   issue_en,
    output id_dispatch_t             issue_inst [ISSUE_WIDTH]
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;
    id_dispatch_t     entries [DEPTH];

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] head1_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] tail1_idx;
    logic             enq_fire;
    issue_cnt_t       enq_cnt;
    issue_cnt_t       deq_cnt;
    logic [1:0]       cand_valid;
    id_dispatch_t     cand [2];
    logic [1:0]       issue_en_next;

    // Enqueue handshake: lane l is accepted when in_valid[l] && in_ready && !flush.
    // in_ready never depends on in_valid; the decoder holds its lanes until in_ready.
    assign in_ready       = (count <= PTR_W'(DEPTH - 2));
    assign pause_dispatch = !in_ready;
    assign enq_fire       = in_ready && !flush;
    assign enq_cnt        = enq_fire ? lane_count(in_valid) : '0;

    assign head_idx  = head[IDX_W-1:0];
    assign head1_idx = head_idx + IDX_W'(1);
    assign tail_idx  = tail[IDX_W-1:0];
    assign tail1_idx = tail_idx + IDX_W'(1);

    assign cand_valid = {count >= PTR_W'(2), count != '0};
    assign cand[0]    = entries[head_idx];
    assign cand[1]    = entries[head1_idx];

    issue_pair_check u_pair_check (
        .cand_valid     (cand_valid),
        .cand           (cand),
        .cur_issue_en   (issue_en),
        .cur_issue_inst (issue_inst),
        .issue_en_next  (issue_en_next)
    );

    assign deq_cnt = (flush || stall) ? '0 : lane_count(issue_en_next);

    // Lanes are compacted: a lone lane 1 lands at tail.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            if (in_valid == 2'b10) begin
                entries[tail_idx] <= in_inst[1];
            end else begin
                if (in_valid[0]) entries[tail_idx]  <= in_inst[0];
                if (in_valid[1]) entries[tail1_idx] <= in_inst[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_cnt);
            tail  <= tail + PTR_W'(enq_cnt);
            count <= count + PTR_W'(enq_cnt) - PTR_W'(deq_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_en <= '0;
            for (int s = 0; s < ISSUE_WIDTH; s++) issue_inst[s] <= '0;
        end else if (flush) begin
            issue_en <= '0;
            for (int s = 0; s < ISSUE_WIDTH; s++) issue_inst[s] <= '0;
        end else if (!stall) begin
            issue_en <= issue_en_next;
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                issue_inst[s] <= issue_en_next[s] ? cand[s] : '0;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_issue_queue.sv
// Bench for dispatch_issue_queue: pairing-rule vector table, directed stall, wrap,
// flush and async-reset sequences, then random traffic against a queue-level model.
module tb_dispatch_issue_queue;
    import pipeline_types::*;

    localparam int DEPTH = 8;
    localparam int W     = $bits(id_dispatch_t);
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_LD   = 4'b1100;
    localparam logic [3:0] F_MEM  = 4'b0100;
    localparam logic [3:0] F_BR   = 4'b0010;
    localparam logic [3:0] F_SER  = 4'b0001;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         stall = 1'b0;
    logic [1:0]   in_valid = '0;
    id_dispatch_t in_inst [2];
    logic         in_ready;
    logic         pause_dispatch;
    logic [1:0]   issue_en;
    id_dispatch_t issue_inst [2];

    int checks = 0;
    int errors = 0;

    // Reference state: queue contents in program order plus the modelled issue registers.
    logic [W-1:0] exp_q [$];
    logic [1:0]   m_en;
    id_dispatch_t m_inst [2];

    dispatch_issue_queue #(.DEPTH(DEPTH), .DECODER_WIDTH(2), .ISSUE_WIDTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .stall          (stall),
        .in_valid       (in_valid),
        .in_inst        (in_inst),
        .in_ready       (in_ready),
        .pause_dispatch (pause_dispatch),
        .issue_en       (issue_en),
        .issue_inst     (issue_inst)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic id_dispatch_t mk(input logic [15:0] p, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [1:0] re, input logic [3:0] f);
        id_dispatch_t i;
        i = '0;
        i.payload          = p;
        i.reg_write_en     = 1'b1;
        i.reg_write_addr   = rd;
        i.reg_read_en      = re;
        i.reg_read_addr[0] = rs1;
        i.reg_read_addr[1] = rs2;
        {i.is_load, i.is_mem, i.is_branch, i.is_serial} = f;
        return i;
    endfunction

    function automatic id_dispatch_t rand_inst(input logic [15:0] p);
        logic [3:0] f;
        case ($urandom_range(0, 9))
            0: f = F_LD;
            1: f = F_MEM;
            2: f = F_BR;
            3: f = F_SER;
            default: f = F_NONE;
        endcase
        return mk(p, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), f);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic reads(input id_dispatch_t i, input logic [4:0] a);
        return (i.reg_read_en[0] && i.reg_read_addr[0] == a) || (i.reg_read_en[1] && i.reg_read_addr[1] == a);
    endfunction

    function automatic logic waits_on_load(input id_dispatch_t c);
        for (int s = 0; s < 2; s++)
            if (m_en[s] && m_inst[s].is_load && m_inst[s].reg_write_en && m_inst[s].reg_write_addr != 0 &&
                reads(c, m_inst[s].reg_write_addr)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_pick();
        id_dispatch_t a, b;
        if (exp_q.size() == 0) return 0;
        a = id_dispatch_t'(exp_q[0]);
        if (waits_on_load(a)) return 0;
        if (exp_q.size() < 2) return 1;
        b = id_dispatch_t'(exp_q[1]);
        if (waits_on_load(b) || a.is_branch || a.is_serial || b.is_serial || (a.is_mem && b.is_mem)) return 1;
        if (a.reg_write_en && a.reg_write_addr != 0 && reads(b, a.reg_write_addr)) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_en = '0;
        m_inst[0] = '0;
        m_inst[1] = '0;
    endtask

    task automatic model_edge();
        int  n;
        logic rdy;
        rdy = (DEPTH - exp_q.size()) >= 2;
        n   = model_pick();
        if (flush) begin
            model_reset();
        end else begin
            if (!stall) begin
                m_en = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
                for (int s = 0; s < 2; s++) begin
                    if (s < n) m_inst[s] = id_dispatch_t'(exp_q[s]);
                    else       m_inst[s] = '0;
                end
                for (int s = 0; s < n; s++) void'(exp_q.pop_front());
            end
            if (rdy)
                for (int l = 0; l < 2; l++) if (in_valid[l]) exp_q.push_back(in_inst[l]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        logic rdy;
        model_edge();
        @(posedge clk);
        #1;
        rdy = (DEPTH - exp_q.size()) >= 2;
        chk("issue_en", 64'(issue_en), 64'(m_en));
        chk("issue_inst0", 64'(issue_inst[0]), 64'(m_inst[0]));
        chk("issue_inst1", 64'(issue_inst[1]), 64'(m_inst[1]));
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("pause_dispatch", 64'(pause_dispatch), 64'(!rdy));
    endtask

    task automatic do_flush();
        flush    = 1'b1;
        stall    = 1'b0;
        in_valid = '0;
        tick();
        flush = 1'b0;
    endtask

    task automatic push(input logic [1:0] v, input id_dispatch_t a, input id_dispatch_t b);
        in_valid   = v;
        in_inst[0] = a;
        in_inst[1] = b;
        tick();
        in_valid = '0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string        name;
        id_dispatch_t a;
        id_dispatch_t b;
        logic [5:0]   exp_seq;  // issue_en after E+1, E+2, E+3 (MSBs first)
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [15:0] tag;
        in_inst[0] = '0;
        in_inst[1] = '0;
        model_reset();

        vecs[0]  = '{"indep_pair",    mk(16'h0001, 1, 2, 3, 2'b11, F_NONE), mk(16'h0002, 2, 4, 5, 2'b11, F_NONE), 6'b11_00_00};
        vecs[1]  = '{"raw_pair",      mk(16'h0011, 3, 1, 2, 2'b11, F_NONE), mk(16'h0012, 4, 3, 5, 2'b11, F_NONE), 6'b01_01_00};
        vecs[2]  = '{"load_use",      mk(16'h0021, 6, 1, 0, 2'b11, F_LD),   mk(16'h0022, 7, 6, 0, 2'b11, F_NONE), 6'b01_00_01};
        vecs[3]  = '{"mem_mem",       mk(16'h0031, 0, 1, 2, 2'b11, F_MEM),  mk(16'h0032, 0, 3, 4, 2'b11, F_MEM),  6'b01_01_00};
        vecs[4]  = '{"branch_slot0",  mk(16'h0041, 0, 1, 2, 2'b11, F_BR),   mk(16'h0042, 8, 9, 10, 2'b11, F_NONE), 6'b01_01_00};
        vecs[5]  = '{"serial_slot1",  mk(16'h0051, 8, 1, 2, 2'b11, F_NONE), mk(16'h0052, 9, 3, 4, 2'b11, F_SER),  6'b01_01_00};
        vecs[6]  = '{"serial_slot0",  mk(16'h0061, 8, 1, 2, 2'b11, F_SER),  mk(16'h0062, 9, 3, 4, 2'b11, F_NONE), 6'b01_01_00};
        vecs[7]  = '{"r0_no_raw",     mk(16'h0071, 0, 1, 2, 2'b11, F_NONE), mk(16'h0072, 3, 0, 0, 2'b11, F_NONE), 6'b11_00_00};
        vecs[8]  = '{"mem_slot1_only",mk(16'h0081, 5, 1, 2, 2'b11, F_NONE), mk(16'h0082, 9, 1, 0, 2'b11, F_LD),   6'b11_00_00};
        vecs[9]  = '{"raw_port1",     mk(16'h0091, 5, 1, 2, 2'b11, F_NONE), mk(16'h0092, 6, 7, 5, 2'b10, F_NONE), 6'b01_01_00};
        vecs[10] = '{"read_disabled", mk(16'h00a1, 5, 1, 2, 2'b11, F_NONE), mk(16'h00a2, 6, 5, 5, 2'b00, F_NONE), 6'b11_00_00};
        vecs[11] = '{"load_r0",       mk(16'h00b1, 0, 1, 2, 2'b11, F_LD),   mk(16'h00b2, 3, 0, 0, 2'b11, F_NONE), 6'b11_00_00};
        vecs[12] = '{"mem_then_alu",  mk(16'h00c1, 4, 1, 2, 2'b11, F_MEM),  mk(16'h00c2, 6, 7, 8, 2'b11, F_NONE), 6'b11_00_00};

        // ---- reset ----
        #1 rst = 1'b0;
        #2;
        chk("rst_issue_en", 64'(issue_en), 64'(0));
        chk("rst_issue_inst0", 64'(issue_inst[0]), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_pause", 64'(pause_dispatch), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // ---- pairing-rule table ----
        foreach (vecs[v]) begin
            do_flush();
            push(2'b11, vecs[v].a, vecs[v].b);
            for (int k = 0; k < 3; k++) begin
                tick();
                chk(vecs[v].name, 64'(issue_en), 64'(vecs[v].exp_seq[5 - 2*k -: 2]));
                if (k == 0) chk({vecs[v].name, "_slot0"}, 64'(issue_inst[0].payload), 64'(vecs[v].a.payload));
            end
        end

        // ---- stall fills queue to DEPTH-1 while issue registers hold ----
        do_flush();
        push(2'b11, mk(16'h0100, 10, 0, 0, 2'b11, F_NONE), mk(16'h0101, 11, 0, 0, 2'b11, F_NONE));
        tick();
        chk("stall_pre_en", 64'(issue_en), 64'(2'b11));
        stall = 1'b1;
        push(2'b01, mk(16'h0200, 12, 0, 0, 2'b11, F_NONE), '0);
        tag = 16'h0201;
        for (int i = 0; i < 5; i++) begin
            push(2'b11, mk(tag, 5'(13 + i), 0, 0, 2'b11, F_NONE), mk(tag + 16'h1, 5'(20 + i), 0, 0, 2'b11, F_NONE));
            tag = tag + 16'h2;
            chk("stall_hold_en", 64'(issue_en), 64'(2'b11));
            chk("stall_hold_inst", 64'(issue_inst[0].payload), 64'(16'h0100));
        end
        chk("stall_full_ready", 64'(in_ready), 64'(0));
        chk("stall_full_pause", 64'(pause_dispatch), 64'(1));
        stall = 1'b0;
        tick();
        chk("stall_release_en", 64'(issue_en), 64'(2'b11));
        chk("stall_release_order", 64'(issue_inst[0].payload), 64'(16'h0200));
        for (int i = 0; i < 4; i++) tick();

        // ---- wrap head to index 7, fill to 5, flush with both lanes valid ----
        do_flush();
        for (int i = 0; i < 3; i++)
            push(2'b11, mk(16'h0300 + 16'(2*i), 5'(2 + i), 0, 0, 2'b11, F_NONE),
                        mk(16'h0301 + 16'(2*i), 5'(8 + i), 0, 0, 2'b11, F_NONE));
        push(2'b01, mk(16'h0306, 15, 0, 0, 2'b11, F_NONE), '0);
        for (int i = 0; i < 4; i++) tick();
        stall = 1'b1;
        push(2'b11, mk(16'h0400, 1, 0, 0, 2'b11, F_NONE), mk(16'h0401, 2, 0, 0, 2'b11, F_NONE));
        push(2'b11, mk(16'h0402, 3, 0, 0, 2'b11, F_NONE), mk(16'h0403, 4, 0, 0, 2'b11, F_NONE));
        push(2'b01, mk(16'h0404, 5, 0, 0, 2'b11, F_NONE), '0);
        flush = 1'b1;
        push(2'b11, mk(16'h0f00, 6, 0, 0, 2'b11, F_NONE), mk(16'h0f01, 7, 0, 0, 2'b11, F_NONE));
        flush = 1'b0;
        stall = 1'b0;
        chk("flush_ready", 64'(in_ready), 64'(1));
        chk("flush_pause", 64'(pause_dispatch), 64'(0));
        chk("flush_issue_en", 64'(issue_en), 64'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flushed_never_issue", 64'(issue_en), 64'(0));
        end

        // ---- asynchronous reset mid-drain ----
        do_flush();
        push(2'b11, mk(16'h0500, 1, 0, 0, 2'b11, F_NONE), mk(16'h0501, 2, 0, 0, 2'b11, F_NONE));
        push(2'b11, mk(16'h0502, 3, 0, 0, 2'b11, F_NONE), mk(16'h0503, 4, 0, 0, 2'b11, F_NONE));
        chk("arst_pre_en", 64'(issue_en), 64'(2'b11));
        #2 rst = 1'b0;
        #1;
        chk("arst_issue_en", 64'(issue_en), 64'(0));
        chk("arst_issue_inst0", 64'(issue_inst[0]), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("arst_empty_en", 64'(issue_en), 64'(0));
        tick();
        chk("arst_empty_en2", 64'(issue_en), 64'(0));

        // ---- randomized traffic against the model ----
        tag = 16'h1000;
        for (int c = 0; c < 600; c++) begin
            flush    = ($urandom_range(0, 99) < 3);
            stall    = ($urandom_range(0, 99) < 20);
            in_valid = 2'($urandom_range(0, 3));
            in_inst[0] = rand_inst(tag);
            in_inst[1] = rand_inst(tag + 16'h1);
            tag = tag + 16'h2;
            tick();
        end
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = '0;
        for (int c = 0; c < 10; c++) tick();

        // ---- report ----
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
